// File: rtl/gen_sec.sv
// Serial frame generator: header pattern, data MSB first, optional even parity, idle gap.
// Drives the single-bit link consumed by det_sec.s_in.
module gen_sec #(
    parameter int                      ANCHO_DATO   = 4,
    parameter int                      ANCHO_PATRON = 4,
    parameter logic [ANCHO_PATRON-1:0] PATRON       = 4'b1101,
    parameter int                      PARIDAD      = 1,
    parameter int                      MIN_IDLE     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ANCHO_DATO-1:0] dato,
    input  logic                  cargar,
    output logic                  listo,
    output logic                  s_out,
    output logic                  enviando,
    output logic                  fin_trama
);

    localparam int MAX_AB  = (ANCHO_PATRON > ANCHO_DATO) ? ANCHO_PATRON : ANCHO_DATO;
    localparam int MAX_CNT = (MAX_AB > MIN_IDLE) ? MAX_AB : MIN_IDLE;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CABECERA,
        S_DATO,
        S_PARIDAD,
        S_ESPERA
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ANCHO_DATO-1:0] dato_q, dato_d;
    logic                  s_out_q, s_out_d;
    logic                  enviando_q, enviando_d;
    logic                  fin_trama_q, fin_trama_d;

    estado_t               tras_datos;
    logic [CW-1:0]         cnt_tras_datos;
    logic                  bit_pat;
    logic                  bit_dat;

    assign listo     = (estado_q == S_IDLE);
    assign s_out     = s_out_q;
    assign enviando  = enviando_q;
    assign fin_trama = fin_trama_q;

    // Next state and counter; cnt always holds the index of the bit shown on s_out.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        dato_d   = dato_q;

        if (MIN_IDLE > 0) begin
            tras_datos     = S_ESPERA;
            cnt_tras_datos = CW'((MIN_IDLE > 0) ? MIN_IDLE - 1 : 0);
        end else begin
            tras_datos     = S_IDLE;
            cnt_tras_datos = '0;
        end

        case (estado_q)
            S_IDLE: begin
                if (cargar) begin
                    estado_d = S_CABECERA;
                    cnt_d    = CW'(ANCHO_PATRON - 1);
                    dato_d   = dato;
                end
            end
            S_CABECERA: begin
                if (cnt_q == '0) begin
                    estado_d = S_DATO;
                    cnt_d    = CW'(ANCHO_DATO - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATO: begin
                if (cnt_q == '0) begin
                    if (PARIDAD != 0) begin
                        estado_d = S_PARIDAD;
                        cnt_d    = '0;
                    end else begin
                        estado_d = tras_datos;
                        cnt_d    = cnt_tras_datos;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PARIDAD: begin
                estado_d = tras_datos;
                cnt_d    = cnt_tras_datos;
            end
            S_ESPERA: begin
                if (cnt_q == '0) begin
                    estado_d = S_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                estado_d = S_IDLE;
                cnt_d    = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register alongside it.
    always_comb begin
        bit_pat = 1'b0;
        for (int unsigned i = 0; i < ANCHO_PATRON; i++) begin
            if (cnt_d == CW'(i)) begin
                bit_pat = PATRON[i];
            end
        end

        bit_dat = 1'b0;
        for (int unsigned i = 0; i < ANCHO_DATO; i++) begin
            if (cnt_d == CW'(i)) begin
                bit_dat = dato_d[i];
            end
        end

        s_out_d     = 1'b0;
        enviando_d  = 1'b0;
        fin_trama_d = 1'b0;

        case (estado_d)
            S_CABECERA: begin
                s_out_d    = bit_pat;
                enviando_d = 1'b1;
            end
            S_DATO: begin
                s_out_d     = bit_dat;
                enviando_d  = 1'b1;
                fin_trama_d = (PARIDAD == 0) && (cnt_d == '0);
            end
            S_PARIDAD: begin
                s_out_d     = ^dato_d;
                enviando_d  = 1'b1;
                fin_trama_d = 1'b1;
            end
            default: begin
                s_out_d     = 1'b0;
                enviando_d  = 1'b0;
                fin_trama_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= S_IDLE;
            cnt_q       <= '0;
            dato_q      <= '0;
            s_out_q     <= 1'b0;
            enviando_q  <= 1'b0;
            fin_trama_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            dato_q      <= dato_d;
            s_out_q     <= s_out_d;
            enviando_q  <= enviando_d;
            fin_trama_q <= fin_trama_d;
        end
    end

endmodule

// File: tb/tb_gen_sec.sv
// Directed bench for gen_sec: default instance plus an 8-bit, no-parity, no-gap instance.
module tb_gen_sec;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dato;
    logic       cargar;
    logic       listo, s_out, enviando, fin_trama;
    logic [7:0] dato8;
    logic       cargar8;
    logic       listo8, s_out8, enviando8, fin_trama8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gen_sec u_dut (
        .clk      (clk),
        .rst      (rst),
        .dato     (dato),
        .cargar   (cargar),
        .listo    (listo),
        .s_out    (s_out),
        .enviando (enviando),
        .fin_trama(fin_trama)
    );

    gen_sec #(
        .ANCHO_DATO  (8),
        .ANCHO_PATRON(4),
        .PATRON      (4'b1101),
        .PARIDAD     (0),
        .MIN_IDLE    (0)
    ) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .dato     (dato8),
        .cargar   (cargar8),
        .listo    (listo8),
        .s_out    (s_out8),
        .enviando (enviando8),
        .fin_trama(fin_trama8)
    );

    // Observed vectors below are {s_out, enviando, fin_trama, listo}.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cargar = 1'b0; dato = '0; cargar8 = 1'b0; dato8 = '0;
        step();
        step();
        n_checks++;
        if ({s_out, enviando, fin_trama, listo} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 0001", {s_out, enviando, fin_trama, listo});
        end
        n_checks++;
        if ({s_out8, enviando8, fin_trama8, listo8} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_state8: got %b expected 0001", {s_out8, enviando8, fin_trama8, listo8});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_frame_1010();
        logic [8:0] e;
        e = 9'b110110100;
        dato = 4'b1010; cargar = 1'b1;
        step();
        cargar = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if ({s_out, enviando, fin_trama, listo} !== {e[8-i], 1'b1, (i == 8), 1'b0}) begin
                n_fail++;
                $display("FAIL frame_1010 bit %0d: got %b expected %b", i,
                         {s_out, enviando, fin_trama, listo}, {e[8-i], 1'b1, (i == 8), 1'b0});
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({s_out, enviando, fin_trama, listo} !== 4'b0000) begin
                n_fail++;
                $display("FAIL frame_1010 espera %0d: got %b expected 0000", i,
                         {s_out, enviando, fin_trama, listo});
            end
            step();
        end
        n_checks++;
        if ({s_out, enviando, fin_trama, listo} !== 4'b0001) begin
            n_fail++;
            $display("FAIL frame_1010 idle: got %b expected 0001", {s_out, enviando, fin_trama, listo});
        end
    endtask

    task automatic test_parity_hold();
        logic [8:0] e;
        int         k;
        e = 9'b110101111;
        dato = 4'b0111; cargar = 1'b1;
        step();
        cargar = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if ({s_out, enviando, fin_trama} !== {e[8-i], 1'b1, (i == 8)}) begin
                n_fail++;
                $display("FAIL parity_hold bit %0d: got %b expected %b", i,
                         {s_out, enviando, fin_trama}, {e[8-i], 1'b1, (i == 8)});
            end
            if (i == 2) dato = 4'b0000;
            step();
        end
        k = 0;
        while (!listo && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (listo !== 1'b1 || k !== 2) begin
            n_fail++;
            $display("FAIL parity_hold listo_wait: got listo=%b after %0d cycles expected 1 after 2", listo, k);
        end
    endtask

    task automatic test_back_to_back();
        logic [26:0] es, ee, ef, el;
        es = 27'b110100011_000_110110001_000000;
        ee = 27'b111111111_000_111111111_000000;
        ef = 27'b000000001_000_000000001_000000;
        el = 27'b000000000_001_000000000_001111;
        dato = 4'b0001; cargar = 1'b1;
        step();
        for (int c = 0; c < 27; c++) begin
            n_checks++;
            if ({s_out, enviando, fin_trama, listo} !== {es[26-c], ee[26-c], ef[26-c], el[26-c]}) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c,
                         {s_out, enviando, fin_trama, listo}, {es[26-c], ee[26-c], ef[26-c], el[26-c]});
            end
            if (c == 1)  dato = 4'b1000;
            if (c == 12) cargar = 1'b0;
            if (c == 14) cargar = 1'b1;
            if (c == 15) cargar = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] e;
        e = 9'b110110100;
        dato = 4'b1010; cargar = 1'b1;
        step();
        cargar = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({s_out, enviando} !== {e[8-i], 1'b1}) begin
                n_fail++;
                $display("FAIL reset_mid bit %0d: got %b expected %b", i, {s_out, enviando}, {e[8-i], 1'b1});
            end
            if (i < 6) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({s_out, enviando, fin_trama, listo} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid abort: got %b expected 0001", {s_out, enviando, fin_trama, listo});
        end
        step();
        n_checks++;
        if ({s_out, enviando, fin_trama, listo} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid no_resume: got %b expected 0001", {s_out, enviando, fin_trama, listo});
        end
        e = 9'b110101111;
        dato = 4'b0111; cargar = 1'b1;
        step();
        cargar = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if ({s_out, enviando, fin_trama, listo} !== {e[8-i], 1'b1, (i == 8), 1'b0}) begin
                n_fail++;
                $display("FAIL reset_mid refill bit %0d: got %b expected %b", i,
                         {s_out, enviando, fin_trama, listo}, {e[8-i], 1'b1, (i == 8), 1'b0});
            end
            step();
        end
        step();
        step();
        n_checks++;
        if (listo !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid final_listo: got %b expected 1", listo);
        end
    endtask

    task automatic test_wide_no_parity();
        logic [11:0] e;
        e = 12'b1101_1010_0101;
        dato8 = 8'hA5; cargar8 = 1'b1;
        step();
        cargar8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if ({s_out8, enviando8, fin_trama8, listo8} !== {e[11-i], 1'b1, (i == 11), 1'b0}) begin
                n_fail++;
                $display("FAIL wide bit %0d: got %b expected %b", i,
                         {s_out8, enviando8, fin_trama8, listo8}, {e[11-i], 1'b1, (i == 11), 1'b0});
            end
            step();
        end
        n_checks++;
        if ({s_out8, enviando8, fin_trama8, listo8} !== 4'b0001) begin
            n_fail++;
            $display("FAIL wide listo_next: got %b expected 0001", {s_out8, enviando8, fin_trama8, listo8});
        end
    endtask

    initial begin
        test_reset();
        test_frame_1010();
        test_parity_hold();
        test_back_to_back();
        test_reset_mid_frame();
        test_wide_no_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gen_sec.md
Name: gen_sec

Overview:
Serial frame generator: the transmit end of the single-bit link that det_sec receives on s_in. Accepts a parallel number through a ready/valid handshake and serializes it as: fixed header pattern, data bits MSB first, optional even-parity bit, then an idle gap of zeros. Drives s_out, which connects directly to det_sec.s_in in loopback benches and in the top level.

Parameters:
ANCHO_DATO, 4, data word width in bits (>=1)
ANCHO_PATRON, 4, header pattern width in bits (>=1)
PATRON, 4'b1101, header bits, sent MSB first
PARIDAD, 1, 1 = append even-parity bit after data; 0 = no parity bit
MIN_IDLE, 2, zero bits forced after each frame before listo reasserts (>=0)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
dato  input  ANCHO_DATO  number to send, sampled only on handshake
cargar  input  1  request: dato valid this cycle
listo  output  1  ready: generator in IDLE, accepts this cycle
s_out  output  1  serial line, registered
enviando  output  1  high while a header, data or parity bit is on s_out
fin_trama  output  1  one-cycle pulse while the last frame bit is on s_out

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, s_out=0, enviando=0, fin_trama=0, listo=1. Holding, counter and latched data are cleared. Reset mid-frame abandons the frame. No partial bits follow, and nothing resumes.
- Handshake: transfer occurs on an edge where cargar=1 and listo=1. dato is latched into the shift register. cargar while listo=0 is ignored, not queued. listo is combinational from state (=1 only in IDLE).
- Latency: handshake at edge k puts PATRON[ANCHO_PATRON-1] on s_out during cycle k+1. One bit per clock thereafter, with no stalls.
- States:
  - IDLE: s_out=0. On handshake go to CABECERA.
  - CABECERA: emit PATRON MSB first over ANCHO_PATRON cycles, then go to DATO.
  - DATO: emit latched data MSB first over ANCHO_DATO cycles. Then go to PARIDAD if PARIDAD=1. Otherwise go to ESPERA, or to IDLE if MIN_IDLE=0.
  - PARIDAD: one cycle. s_out = XOR of all latched data bits, so the ones count over data+parity is even. Then go to ESPERA, or to IDLE if MIN_IDLE=0.
  - ESPERA: s_out=0 for exactly MIN_IDLE cycles, then go to IDLE.
- Frame length = ANCHO_PATRON + ANCHO_DATO + PARIDAD bits.
- Minimum gap between frames is MIN_IDLE+1 zeros, because the IDLE cycle where the handshake occurs also outputs 0.
- enviando=1 exactly during CABECERA, DATO and PARIDAD.
- fin_trama=1 during the final data bit (PARIDAD=0) or during the parity bit (PARIDAD=1). It is never high outside enviando.
- Bit counter is one shared down-counter, width $clog2(max(ANCHO_PATRON, ANCHO_DATO, MIN_IDLE)+1), reloaded on every state entry. The bit position must not wrap or skip.
- Changes to dato after the handshake must not affect the frame in progress.
- cargar held high continuously: a new frame is accepted on every IDLE cycle, giving frames back-to-back with the minimum gap.

Test Plan:
- Defaults, dato=4'b1010, single cargar pulse -> s_out over the next 9 cycles = 1,1,0,1,1,0,1,0,0. fin_trama high on the 9th. Then 2 ESPERA zeros, then listo=1. enviando high for exactly 9 cycles.
- Defaults, dato=4'b0111 -> s_out = 1,1,0,1,0,1,1,1,1 (parity 1). Change dato to 4'b0000 mid-frame -> frame unchanged.
- cargar held high, dato=4'b0001 then 4'b1000 -> two frames separated by exactly 3 zero cycles (2 ESPERA + 1 IDLE). cargar pulses during busy cycles are ignored (no third frame).
- rst asserted during the 3rd data bit -> next cycle s_out=0, enviando=0, listo=1. A new handshake afterwards sends a complete, correct frame.
- PARIDAD=0, MIN_IDLE=0, ANCHO_DATO=8, dato=8'hA5 -> 12-bit frame 1101_10100101. fin_trama on the last data bit. listo=1 on the very next cycle.
- Loopback: s_out connected to det_sec.s_in with matching parameters, 10 random numbers -> exactly one nuevo_numero per frame and valido asserted for every frame.
